// File: rtl/ram_stream_reader_if.sv
// Bus bundle between ram_stream_reader and its neighbours.
//   RAM read port  : rd_valid_addr, rd_addr (to RAM), rd_data, rd_valid_data (from RAM)
//   Output stream  : m_valid, m_data, m_last (to consumer), m_ready (from consumer)
// master = reader side, slave = RAM / consumer side.
interface ram_stream_reader_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDR_LEN = 5
);
    logic                rd_valid_addr;
    logic [ADDR_LEN-1:0] rd_addr;
    logic [WIDTH-1:0]    rd_data;
    logic                rd_valid_data;
    logic                m_valid;
    logic [WIDTH-1:0]    m_data;
    logic                m_last;
    logic                m_ready;

    modport master (
        output rd_valid_addr, rd_addr,
        input  rd_data, rd_valid_data,
        output m_valid, m_data, m_last,
        input  m_ready
    );

    modport slave (
        input  rd_valid_addr, rd_addr,
        output rd_data, rd_valid_data,
        input  m_valid, m_data, m_last,
        output m_ready
    );
endinterface

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: walks len addresses from base_addr (modulo DEPTH) on the
// single-cycle-latency RAM read port and streams the returned words out on a
// valid/ready interface with a last-beat marker. Read strobes are credit
// limited so the output buffer can never overflow.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           command strobe, sampled only in IDLE
//   base_addr, len  command; latched on acceptance (len 0..DEPTH)
//   stride          address step (only with RAM_STREAM_READER_STRIDE_EN)
//   busy, done      busy from accepted start until done; done is a 1-cycle pulse
//   bus             RAM read port + output stream (ram_stream_reader_if.master)
//
// Optional feature macro: RAM_STREAM_READER_STRIDE_EN (adds the stride port;
// without it the address step is fixed at 1).
module ram_stream_reader #(
    parameter  int unsigned DEPTH      = 32,
    parameter  int unsigned WIDTH      = 32,
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned ADDR_LEN   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_LEN-1:0] base_addr,
    input  logic [ADDR_LEN:0]   len,
`ifdef RAM_STREAM_READER_STRIDE_EN
    input  logic [ADDR_LEN-1:0] stride,
`endif
    output logic                busy,
    output logic                done,
    ram_stream_reader_if.master bus
);

    localparam int unsigned CNT_W     = ADDR_LEN + 1;
    // Holds FIFO_DEPTH + 1 so the credit sum cannot wrap.
    localparam int unsigned FCNT_W    = $clog2(FIFO_DEPTH + 2);
    // The output register is the FIFO head; the memory holds the rest.
    localparam int unsigned MEM_DEPTH = FIFO_DEPTH - 1;
    localparam int unsigned PTR_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                accept_c;
    logic                issue_c;

    logic [CNT_W-1:0]    len_q;
    logic [ADDR_LEN-1:0] step_q;
    logic [ADDR_LEN-1:0] next_addr_q;
    logic [CNT_W-1:0]    issue_cnt_q;
    logic [CNT_W-1:0]    load_cnt_q;
    logic                inflight_q;

    logic [FCNT_W-1:0]   fifo_cnt_q;
    logic [FCNT_W-1:0]   fifo_cnt_d;
    logic [FCNT_W-1:0]   mem_cnt_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [WIDTH-1:0]    mem_q [MEM_DEPTH];

    logic                push_c;
    logic                pop_c;
    logic                load_out_c;
    logic                mem_rd_c;
    logic                mem_wr_c;
    logic                bypass_c;
    logic                last_c;
    logic                credit_ok_c;
    logic                last_beat_c;
    logic [ADDR_LEN-1:0] step_in_c;
    logic [ADDR_LEN-1:0] issue_addr_c;
    logic [ADDR_LEN-1:0] issue_step_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MEM_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

`ifdef RAM_STREAM_READER_STRIDE_EN
    assign step_in_c = stride;
`else
    assign step_in_c = ADDR_LEN'(1);
`endif

    // Returned data only counts when a strobe is outstanding; stale valids are dropped.
    assign push_c      = bus.rd_valid_data & inflight_q;
    assign pop_c       = bus.m_valid & bus.m_ready;
    assign last_beat_c = pop_c & bus.m_last;

    // Output register refills whenever it is empty or being consumed.
    assign load_out_c = !bus.m_valid || pop_c;
    assign mem_rd_c   = load_out_c && (mem_cnt_q != '0);
    assign bypass_c   = load_out_c && (mem_cnt_q == '0) && push_c;
    assign mem_wr_c   = push_c && !bypass_c;
    assign last_c     = (load_cnt_q + CNT_W'(1)) == len_q;

    // Credit for next cycle's strobe: occupancy after this edge plus the strobe
    // now on the bus (whose data returns next cycle) must leave a free slot.
    assign fifo_cnt_d  = fifo_cnt_q + FCNT_W'(push_c) - FCNT_W'(pop_c);
    assign credit_ok_c = (fifo_cnt_d + FCNT_W'(bus.rd_valid_addr)) < FCNT_W'(FIFO_DEPTH);

    // The first strobe comes straight from the command inputs.
    assign issue_addr_c = (state_q == IDLE) ? base_addr : next_addr_q;
    assign issue_step_c = (state_q == IDLE) ? step_in_c : step_q;

    // Next-state and strobe-issue decision.
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        issue_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept_c = 1'b1;
                    if (len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        issue_c = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue_cnt_q == len_q) begin
                    state_d = DRAIN;
                end else if (credit_ok_c) begin
                    issue_c = 1'b1;
                end
            end
            DRAIN: begin
                if (last_beat_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, command, strobe, and FIFO control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            busy              <= 1'b0;
            done              <= 1'b0;
            len_q             <= '0;
            step_q            <= '0;
            next_addr_q       <= '0;
            issue_cnt_q       <= '0;
            load_cnt_q        <= '0;
            inflight_q        <= 1'b0;
            fifo_cnt_q        <= '0;
            mem_cnt_q         <= '0;
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            bus.rd_valid_addr <= 1'b0;
            bus.rd_addr       <= '0;
            bus.m_valid       <= 1'b0;
            bus.m_data        <= '0;
            bus.m_last        <= 1'b0;
        end else begin
            state_q           <= state_d;
            busy              <= (state_d != IDLE);
            done              <= (state_d == DONE);
            bus.rd_valid_addr <= issue_c;
            inflight_q        <= bus.rd_valid_addr;
            fifo_cnt_q        <= fifo_cnt_d;

            if (accept_c) begin
                len_q  <= len;
                step_q <= step_in_c;
            end

            if (issue_c) begin
                bus.rd_addr <= issue_addr_c;
                next_addr_q <= issue_addr_c + issue_step_c;
                issue_cnt_q <= accept_c ? CNT_W'(1) : issue_cnt_q + CNT_W'(1);
            end else if (accept_c) begin
                issue_cnt_q <= '0;
            end

            if (accept_c) begin
                load_cnt_q <= '0;
            end else if (mem_rd_c || bypass_c) begin
                load_cnt_q <= load_cnt_q + CNT_W'(1);
            end

            if (mem_rd_c) begin
                bus.m_valid <= 1'b1;
                bus.m_data  <= mem_q[rd_ptr_q];
                bus.m_last  <= last_c;
                rd_ptr_q    <= ptr_inc(rd_ptr_q);
            end else if (bypass_c) begin
                bus.m_valid <= 1'b1;
                bus.m_data  <= bus.rd_data;
                bus.m_last  <= last_c;
            end else if (load_out_c) begin
                bus.m_valid <= 1'b0;
                bus.m_last  <= 1'b0;
            end

            if (mem_wr_c) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            mem_cnt_q <= mem_cnt_q + FCNT_W'(mem_wr_c) - FCNT_W'(mem_rd_c);
        end
    end

    // Buffer storage; contents are don't-care while the counters say empty.
    always_ff @(posedge clk) begin
        if (mem_wr_c) begin
            mem_q[wr_ptr_q] <= bus.rd_data;
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader with a 1-cycle-latency RAM model
// (RAM[k] = k + 100) and a scoreboard of expected addresses and beats.
module tb_ram_stream_reader;

    localparam int unsigned DEPTH      = 32;
    localparam int unsigned WIDTH      = 32;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned ADDR_LEN   = 5;
    localparam int unsigned LEN_W      = ADDR_LEN + 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [ADDR_LEN-1:0] base_addr;
    logic [LEN_W-1:0]    len;
    logic                busy;
    logic                done;
`ifdef RAM_STREAM_READER_STRIDE_EN
    logic [ADDR_LEN-1:0] stride;
`endif
    logic                stray;

    ram_stream_reader_if #(.WIDTH(WIDTH), .ADDR_LEN(ADDR_LEN)) bus ();

    ram_stream_reader #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .base_addr(base_addr),
        .len(len),
`ifdef RAM_STREAM_READER_STRIDE_EN
        .stride(stride),
`endif
        .busy(busy),
        .done(done),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // RAM model: registered data and valid one cycle after the strobe.
    logic [WIDTH-1:0] ram [DEPTH];
    always @(posedge clk) begin
        bus.rd_valid_data <= bus.rd_valid_addr | stray;
        bus.rd_data       <= ram[bus.rd_addr];
    end

    int vectors = 0;
    int miscompares = 0;

    logic [ADDR_LEN-1:0] exp_addr_q [$];
    logic [WIDTH-1:0]    exp_data_q [$];
    bit                  exp_last_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stream monitor: strobe addresses, beats, credit, buffer occupancy, hold.
    int               strobes;
    int               beats;
    int               occ;
    bit               prev_strobe;
    bit               hold_pending;
    logic [WIDTH+1:0] hold_snap;
    always @(negedge clk) begin
        if (rst) begin
            strobes      = 0;
            beats        = 0;
            occ          = 0;
            prev_strobe  = 1'b0;
            hold_pending = 1'b0;
        end else begin
            if (bus.rd_valid_addr) begin
                strobes++;
                if (exp_addr_q.size() == 0) check("extra_strobe", 64'(1), 64'(0));
                else check("rd_addr", 64'(bus.rd_addr), 64'(exp_addr_q.pop_front()));
                check("credit", 64'((strobes - beats) <= FIFO_DEPTH), 64'(1));
            end
            if (bus.rd_valid_data && prev_strobe) begin
                check("push_full", 64'((occ < FIFO_DEPTH) || (bus.m_valid && bus.m_ready)), 64'(1));
                occ++;
            end
            if (hold_pending)
                check("hold", 64'({bus.m_valid, bus.m_last, bus.m_data}), 64'(hold_snap));
            if (bus.m_valid && bus.m_ready) begin
                if (exp_data_q.size() == 0) begin
                    check("extra_beat", 64'(1), 64'(0));
                end else begin
                    check("m_data", 64'(bus.m_data), 64'(exp_data_q.pop_front()));
                    check("m_last", 64'(bus.m_last), 64'(exp_last_q.pop_front()));
                end
                beats++;
                occ--;
            end
            prev_strobe  = bus.rd_valid_addr;
            hold_pending = bus.m_valid && !bus.m_ready;
            hold_snap    = {bus.m_valid, bus.m_last, bus.m_data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int b, input int n, input int st);
        int a;
        for (int i = 0; i < n; i++) begin
            a = (b + i * st) % DEPTH;
            exp_addr_q.push_back(ADDR_LEN'(a));
            exp_data_q.push_back(WIDTH'(a + 100));
            exp_last_q.push_back(i == n - 1);
        end
        base_addr = ADDR_LEN'(b);
        len       = LEN_W'(n);
`ifdef RAM_STREAM_READER_STRIDE_EN
        stride    = ADDR_LEN'(st);
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Runs from cycle k0 (cycle 1 = first cycle after the accepting edge) until done.
    task automatic run_cmd(input int k0, input int lo, input int hi, input int probe,
                           output int done_cyc, output int first_v, output logic probe_rva);
        done_cyc  = -1;
        first_v   = -1;
        probe_rva = 1'b1;
        for (int k = k0; k <= 300; k++) begin
            bus.m_ready = !(k >= lo && k <= hi);
            if (k == probe) probe_rva = bus.rd_valid_addr;
            if (first_v < 0 && bus.m_valid) first_v = k;
            if (done) begin
                done_cyc = k;
                break;
            end
            tick();
        end
        if (done_cyc < 0) check("done_timeout", 64'(0), 64'(1));
        bus.m_ready = 1'b1;
    endtask

    task automatic check_idle_after(input string tag);
        tick();
        check(tag, 64'({busy, done}), 64'(0));
        check("queue_empty", 64'(exp_data_q.size() + exp_addr_q.size()), 64'(0));
    endtask

    task automatic check_reset_outputs();
        check("rst_busy",  64'(busy), 64'(0));
        check("rst_done",  64'(done), 64'(0));
        check("rst_rva",   64'(bus.rd_valid_addr), 64'(0));
        check("rst_raddr", 64'(bus.rd_addr), 64'(0));
        check("rst_mval",  64'(bus.m_valid), 64'(0));
        check("rst_mdata", 64'(bus.m_data), 64'(0));
        check("rst_mlast", 64'(bus.m_last), 64'(0));
    endtask

    int   dc;
    int   fv;
    logic pr;

    initial begin
        for (int k = 0; k < DEPTH; k++) ram[k] = WIDTH'(k + 100);
        rst = 1'b1; start = 1'b0; stray = 1'b0;
        base_addr = '0; len = '0; bus.m_ready = 1'b1;
`ifdef RAM_STREAM_READER_STRIDE_EN
        stride = '0;
`endif
        repeat (3) tick();
        check_reset_outputs();
        rst = 1'b0;
        tick();

        // Basic burst: first strobe cycle 1, first beat cycle 3, done cycle 7.
        do_start(0, 4, 1);
        check("t1_busy", 64'(busy), 64'(1));
        check("t1_rva",  64'(bus.rd_valid_addr), 64'(1));
        run_cmd(1, 0, 0, 0, dc, fv, pr);
        check("t1_first_valid", 64'(fv), 64'(3));
        check("t1_done_cyc", 64'(dc), 64'(7));
        check_idle_after("t1_idle");

        // Address wrap, plus a start pulse mid-run that must be ignored.
        do_start(30, 4, 1);
        base_addr = 5'd9; len = 6'd5; start = 1'b1;
        tick();
        start = 1'b0;
        run_cmd(2, 0, 0, 0, dc, fv, pr);
        check("t2_done_cyc", 64'(dc), 64'(7));
        check_idle_after("t2_idle");

        // Backpressure: consumer stalls cycles 4..13; credits run out.
        do_start(3, 8, 1);
        run_cmd(1, 4, 13, 13, dc, fv, pr);
        check("t3_no_strobe_stalled", 64'(pr), 64'(0));
        check_idle_after("t3_idle");

        // Zero-length command.
        do_start(7, 0, 1);
        run_cmd(1, 0, 0, 0, dc, fv, pr);
        check("t4_done_cyc", 64'(dc), 64'(1));
        check("t4_no_beat", 64'(fv), 64'(-1));
        check_idle_after("t4_idle");

        // Full-depth wrap-around read.
        do_start(7, 32, 1);
        run_cmd(1, 0, 0, 0, dc, fv, pr);
        check("t5_done_cyc", 64'(dc), 64'(35));
        check_idle_after("t5_idle");

        // Reset two cycles into a long run, then a stray RAM valid.
        do_start(0, 16, 1);
        tick();
        rst = 1'b1;
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_last_q.delete();
        tick();
        check_reset_outputs();
        rst = 1'b0;
        stray = 1'b1;
        tick();
        stray = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("t6_quiet", 64'({bus.m_valid, busy, bus.rd_valid_addr}), 64'(0));
            tick();
        end
        do_start(5, 2, 1);
        run_cmd(1, 0, 0, 0, dc, fv, pr);
        check("t6_done_cyc", 64'(dc), 64'(5));
        check_idle_after("t6_idle");

`ifdef RAM_STREAM_READER_STRIDE_EN
        do_start(1, 4, 10);
        run_cmd(1, 0, 0, 0, dc, fv, pr);
        check("s1_done_cyc", 64'(dc), 64'(7));
        check_idle_after("s1_idle");
        do_start(1, 3, 0);
        run_cmd(1, 0, 0, 0, dc, fv, pr);
        check("s2_done_cyc", 64'(dc), 64'(6));
        check_idle_after("s2_idle");
`endif

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Read-side initiator for the single-cycle-latency RAM read port (address strobe in, registered data plus valid out one cycle later). On a start command it walks a block of `len` addresses from `base_addr`, wrapping modulo DEPTH. It issues read strobes under credit control and streams the returned words out on a valid/ready interface with a last-beat marker. It sits between the 2D RAM and any consumer (DMA, compute lane) that needs a linear burst of RAM contents with backpressure.

## Interface
- DEPTH, 32, RAM words; power of two.
- WIDTH, 32, data width.
- ADDR_LEN, $clog2(DEPTH), localparam; address width.
- FIFO_DEPTH, 4, output buffer entries and credit limit; ≥ 2.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- base_addr  in  ADDR_LEN  first address.
- len  in  ADDR_LEN+1  word count, 0..DEPTH.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of command.
- rd_valid_addr  out  1  read strobe to RAM.
- rd_addr  out  ADDR_LEN  read address.
- rd_data  in  WIDTH  RAM read data.
- rd_valid_data  in  1  RAM data valid, one cycle after strobe.
- m_valid  out  1  output beat valid.
- m_data  out  WIDTH  output word.
- m_last  out  1  final beat of command.
- m_ready  in  1  consumer accept.

## Operation
- FSM: IDLE → RUN on start with len≠0; IDLE → DONE on start with len=0; RUN → DRAIN when all len strobes are issued; DRAIN → DONE when the last beat is accepted (m_valid&m_ready&m_last); DONE → IDLE unconditionally. done=1 only in DONE. busy=1 in RUN, DRAIN and DONE.
- start outside IDLE is ignored. base_addr and len are latched on acceptance.
- Addressing: issue index i yields rd_addr = (base_addr + i·stride) mod DEPTH, using natural ADDR_LEN-bit wrap. stride is 1 unless the configured stride feature is enabled.
- Credit: a strobe is issued in a cycle only when fifo_count + inflight < FIFO_DEPTH. inflight counts strobes whose data has not yet returned (0..1).
- Returned words (rd_valid_data while inflight≠0) are pushed into the FIFO. rd_valid_data with inflight=0 is discarded; this covers stale RAM valid after reset.
- The FIFO pops on m_valid&m_ready. m_last is asserted on the beat whose pop count equals len.
- Overflow is impossible by credit. The bench checks that no push occurs while the FIFO is full.

## Timing
- Reset values: busy=0, done=0, rd_valid_addr=0, rd_addr=0, m_valid=0, m_data=0, m_last=0. FSM goes to IDLE; counters, inflight and FIFO are cleared.
- rd_valid_addr and rd_addr are registered. Start accepted at edge T gives the first strobe during cycle T+1, data at T+2, and m_valid at T+3.
- With m_ready held high, throughput is 1 beat/cycle. A len=N command completes with done at cycle T+N+3.
- m_valid/m_data/m_last are held stable while m_valid&!m_ready.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- Reset mid-command aborts with no done pulse. The next command behaves exactly as after power-up.
- len=DEPTH reads every word once. Addresses wrap past DEPTH-1 to 0.

## Configuration
- RAM_STREAM_READER_STRIDE_EN defined: adds port stride (in, ADDR_LEN), latched with start. The address step is stride mod DEPTH, and stride=0 repeats base_addr len times.
- Not defined: no stride port; the step is fixed at 1.

## Test plan
- RAM[k]=k+100, base=0, len=4, m_ready=1 → beats 100,101,102,103; m_last on 103; done at T+7; busy low at T+8.
- base=30, len=4, DEPTH=32 → rd_addr sequence 30,31,0,1; data 130,131,100,101.
- len=8, m_ready low for cycles 4–13 → at most 4 words buffered; no strobe while credits are exhausted; all 8 beats delivered in order with no loss or duplication.
- len=0 → no strobe, no beat; done pulses at T+1.
- rst asserted 2 cycles into a len=16 run, with stray rd_valid_data on the following cycle → outputs at reset values; stray word dropped; next base=5, len=2 delivers 105,106 only.
- With RAM_STREAM_READER_STRIDE_EN: base=1, stride=10, len=4 → addresses 1,11,21,31; stride=0, len=3 → address 1 three times.
